// File: rtl/tank_collision_probe.sv
// Tank and bullet collision probe against the tile map.
// Once per frame it samples the tank and bullet positions and walks five probe
// points through a one-cycle-latency tile ROM. It then commits all five flags
// together, so the movement controller always sees one coherent set.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a synchronised rising edge of frame_clk
// LATCH   | capture tank and bullet coordinates
// PROBE0  | issue top probe
// PROBE1  | issue bottom probe, capture top result
// PROBE2  | issue left probe, capture bottom result
// PROBE3  | issue right probe, capture left result
// PROBE4  | issue bullet probe, capture right result
// DRAIN   | capture bullet result
// COMMIT  | load all output flags at once, pulse sweep_done
module tank_collision_probe #(
    parameter int TILE_SHIFT  = 4,
    parameter int MAP_TILES_X = 30,
    parameter int MAP_TILES_Y = 30,
    parameter int ADDR_W      = 10,
    parameter int CODE_W      = 4,
    parameter int BG_CODE     = 0,
    parameter int MARGIN      = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        TankX,
    input  logic [9:0]        TankY,
    input  logic [9:0]        TankS,
    input  logic [9:0]        BulletX,
    input  logic [9:0]        BulletY,
    output logic [ADDR_W-1:0] map_addr,
    output logic              map_rd,
    input  logic [CODE_W-1:0] map_data,
    output logic              top_is_background_color,
    output logic              bottom_is_background_color,
    output logic              left_is_background_color,
    output logic              right_is_background_color,
    output logic              bullet_background,
    output logic              sweep_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_PROBE0,
        S_PROBE1,
        S_PROBE2,
        S_PROBE3,
        S_PROBE4,
        S_DRAIN,
        S_COMMIT
    } state_t;

    localparam logic signed [11:0] MARGIN_S = 12'(MARGIN);

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         frame_sync;
    logic               frame_rise;

    logic [9:0]         tank_x_q;
    logic [9:0]         tank_y_q;
    logic [9:0]         tank_s_q;
    logic [9:0]         bullet_x_q;
    logic [9:0]         bullet_y_q;

    logic signed [11:0] tank_x_s;
    logic signed [11:0] tank_y_s;
    logic signed [11:0] tank_s_s;
    logic signed [11:0] bullet_x_s;
    logic signed [11:0] bullet_y_s;

    logic signed [11:0] probe_x;
    logic signed [11:0] probe_y;
    logic               probe_active;
    logic [11:0]        tile_x;
    logic [11:0]        tile_y;
    logic               probe_off;

    logic               off_q;
    logic               cap_en;
    logic [2:0]         cap_idx;
    logic               data_bg;
    logic               tank_ok;
    logic               bullet_hit;
    logic [4:0]         res_q;

    // frame_clk comes from another domain: two flops to synchronise, a third for edge detect
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_sync <= '0;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
        end
    end

    assign frame_rise = frame_sync[1] & ~frame_sync[2];

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a fixed walk once started; frame edges outside IDLE are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_rise) state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_PROBE0;
            S_PROBE0: state_nxt = S_PROBE1;
            S_PROBE1: state_nxt = S_PROBE2;
            S_PROBE2: state_nxt = S_PROBE3;
            S_PROBE3: state_nxt = S_PROBE4;
            S_PROBE4: state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Snapshot of positions so mid-sweep input changes cannot mix frames
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tank_x_q   <= '0;
            tank_y_q   <= '0;
            tank_s_q   <= '0;
            bullet_x_q <= '0;
            bullet_y_q <= '0;
        end else if (state == S_LATCH) begin
            tank_x_q   <= TankX;
            tank_y_q   <= TankY;
            tank_s_q   <= TankS;
            bullet_x_q <= BulletX;
            bullet_y_q <= BulletY;
        end
    end

    assign tank_x_s   = signed'({2'b00, tank_x_q});
    assign tank_y_s   = signed'({2'b00, tank_y_q});
    assign tank_s_s   = signed'({2'b00, tank_s_q});
    assign bullet_x_s = signed'({2'b00, bullet_x_q});
    assign bullet_y_s = signed'({2'b00, bullet_y_q});

    // Probe point selection; results arrive one cycle later, so each cycle also
    // names which earlier point it captures
    always_comb begin
        probe_x      = '0;
        probe_y      = '0;
        probe_active = 1'b0;
        cap_en       = 1'b0;
        cap_idx      = 3'd0;
        case (state)
            S_PROBE0: begin
                probe_x      = tank_x_s;
                probe_y      = tank_y_s - tank_s_s - MARGIN_S;
                probe_active = 1'b1;
            end
            S_PROBE1: begin
                probe_x      = tank_x_s;
                probe_y      = tank_y_s + tank_s_s + MARGIN_S;
                probe_active = 1'b1;
                cap_en       = 1'b1;
                cap_idx      = 3'd0;
            end
            S_PROBE2: begin
                probe_x      = tank_x_s - tank_s_s - MARGIN_S;
                probe_y      = tank_y_s;
                probe_active = 1'b1;
                cap_en       = 1'b1;
                cap_idx      = 3'd1;
            end
            S_PROBE3: begin
                probe_x      = tank_x_s + tank_s_s + MARGIN_S;
                probe_y      = tank_y_s;
                probe_active = 1'b1;
                cap_en       = 1'b1;
                cap_idx      = 3'd2;
            end
            S_PROBE4: begin
                probe_x      = bullet_x_s;
                probe_y      = bullet_y_s;
                probe_active = 1'b1;
                cap_en       = 1'b1;
                cap_idx      = 3'd3;
            end
            S_DRAIN: begin
                cap_en       = 1'b1;
                cap_idx      = 3'd4;
            end
            default: ;
        endcase
    end

    assign tile_x    = $unsigned(probe_x) >> TILE_SHIFT;
    assign tile_y    = $unsigned(probe_y) >> TILE_SHIFT;
    assign probe_off = probe_x[11] | probe_y[11] |
                       (tile_x >= 12'(MAP_TILES_X)) | (tile_y >= 12'(MAP_TILES_Y));

    // Off-map points never touch the ROM; the address is parked at zero
    assign map_rd   = probe_active & ~probe_off;
    assign map_addr = map_rd ? ADDR_W'(tile_y * MAP_TILES_X + tile_x) : '0;

    assign data_bg    = (map_data == CODE_W'(BG_CODE));
    assign tank_ok    = ~off_q & data_bg;
    assign bullet_hit = off_q | ~data_bg;

    // Off-map status travels alongside the ROM latency; results collect per point
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            off_q <= 1'b0;
            res_q <= '0;
        end else begin
            off_q <= probe_off;
            if (cap_en) begin
                case (cap_idx)
                    3'd0:    res_q[0] <= tank_ok;
                    3'd1:    res_q[1] <= tank_ok;
                    3'd2:    res_q[2] <= tank_ok;
                    3'd3:    res_q[3] <= tank_ok;
                    default: res_q[4] <= bullet_hit;
                endcase
            end
        end
    end

    // Outputs move together only at the end of COMMIT and hold until the next sweep
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            top_is_background_color    <= 1'b0;
            bottom_is_background_color <= 1'b0;
            left_is_background_color   <= 1'b0;
            right_is_background_color  <= 1'b0;
            bullet_background          <= 1'b0;
            sweep_done                 <= 1'b0;
        end else begin
            sweep_done <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                top_is_background_color    <= res_q[0];
                bottom_is_background_color <= res_q[1];
                left_is_background_color   <= res_q[2];
                right_is_background_color  <= res_q[3];
                bullet_background          <= res_q[4];
            end
        end
    end

endmodule
